// File: rtl/encoding_scheduler.sv
// Frame-level scheduler for the encoding slot: checks frame alignment on the
// channel-interleaved acquisition stream, emits one channel per cycle, and
// requests an inference every FRAMES_PER_INF frames.
// It also arbitrates the slot's sample-memory port, handing it to the host
// only between frames.
`timescale 1ns/1ps

module encoding_scheduler #(
  parameter int unsigned CHANNELS       = 128,
  parameter int unsigned FRAMES_PER_INF = 16,
  localparam int unsigned AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic          s_sof,
  input  logic [15:0]   s_data,
  output logic          s_ready,
  output logic          enc_en,
  output logic [15:0]   enc_data,
  output logic [AW-1:0] enc_chan,
  output logic          inf_start,
  input  logic          inference_done,
  input  logic          host_req,
  output logic          host_gnt,
  input  logic          host_wr,
  input  logic [AW-1:0] host_adr,
  input  logic [15:0]   host_dat,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_adr,
  output logic [15:0]   mem_dat,
  output logic          busy,
  output logic          sof_err
);

  localparam int unsigned FW = $clog2(FRAMES_PER_INF + 1) + 1;
  localparam logic [AW-1:0] LAST_CHAN = AW'(CHANNELS - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES_PER_INF - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_INF = 2'd2,
    ST_HOST     = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] chan_q, chan_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          enc_en_q, enc_en_d;
  logic [15:0]   enc_data_q, enc_data_d;
  logic [AW-1:0] enc_chan_q, enc_chan_d;
  logic          inf_start_q, inf_start_d;
  logic          host_gnt_q, host_gnt_d;
  logic          busy_q, busy_d;
  logic          sof_err_q, sof_err_d;
  logic          alive_q;

  logic          hs;
  logic          emit;
  logic [AW-1:0] cur_chan;

  // Stream ready: IDLE yields to a host request; held low while in reset.
  assign s_ready = alive_q & (((state_q == ST_IDLE) & ~host_req) | (state_q == ST_STREAM));
  assign hs      = s_valid & s_ready;

  // Sample-memory port is a straight mux, only live while the host holds the grant.
  assign mem_rd_en = host_gnt_q & ~host_wr & host_req;
  assign mem_wr_en = host_gnt_q & host_wr & host_req;
  assign mem_adr   = host_gnt_q ? host_adr : '0;
  assign mem_dat   = host_gnt_q ? host_dat : '0;

  assign enc_en    = enc_en_q;
  assign enc_data  = enc_data_q;
  assign enc_chan  = enc_chan_q;
  assign inf_start = inf_start_q;
  assign host_gnt  = host_gnt_q;
  assign busy      = busy_q;
  assign sof_err   = sof_err_q;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      chan_q      <= '0;
      frame_q     <= '0;
      enc_en_q    <= 1'b0;
      enc_data_q  <= '0;
      enc_chan_q  <= '0;
      inf_start_q <= 1'b0;
      host_gnt_q  <= 1'b0;
      busy_q      <= 1'b0;
      sof_err_q   <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      frame_q     <= frame_d;
      enc_en_q    <= enc_en_d;
      enc_data_q  <= enc_data_d;
      enc_chan_q  <= enc_chan_d;
      inf_start_q <= inf_start_d;
      host_gnt_q  <= host_gnt_d;
      busy_q      <= busy_d;
      sof_err_q   <= sof_err_d;
      alive_q     <= 1'b1;
    end
  end

  // Next-state, alignment checking, channel/frame counting and output staging.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    frame_d     = frame_q;
    enc_en_d    = 1'b0;
    enc_data_d  = enc_data_q;
    enc_chan_d  = enc_chan_q;
    inf_start_d = 1'b0;
    sof_err_d   = sof_err_q;
    emit        = 1'b0;
    cur_chan    = chan_q;

    unique case (state_q)
      ST_IDLE: begin
        if (host_req) begin
          state_d = ST_HOST;
        end else if (hs) begin
          if (s_sof) begin
            emit     = 1'b1;
            cur_chan = '0;
          end else begin
            // Sample outside any frame: drop it and flag misalignment.
            sof_err_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (hs) begin
          emit = 1'b1;
          if (s_sof && (chan_q != '0)) begin
            // Early start-of-frame: abandon the partial frame and restart at channel 0.
            sof_err_d = 1'b1;
            cur_chan  = '0;
          end
        end
      end
      ST_WAIT_INF: begin
        // A done pulse coincident with our own request cannot belong to it.
        if (inference_done && !inf_start_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOST: begin
        if (!host_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      enc_en_d   = 1'b1;
      enc_data_d = s_data;
      enc_chan_d = cur_chan;
      if (cur_chan == LAST_CHAN) begin
        chan_d = '0;
        if (frame_q == LAST_FRAME) begin
          frame_d     = '0;
          inf_start_d = 1'b1;
          state_d     = ST_WAIT_INF;
        end else begin
          frame_d = FW'(frame_q + FW'(1));
          state_d = ST_IDLE;
        end
      end else begin
        chan_d  = AW'(cur_chan + AW'(1));
        state_d = ST_STREAM;
      end
    end

    host_gnt_d = (state_d == ST_HOST);
    busy_d     = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_encoding_scheduler.sv
// Scoreboard bench for encoding_scheduler with CHANNELS=4, FRAMES_PER_INF=2.
`timescale 1ns/1ps

module tb_encoding_scheduler;

  localparam int unsigned CH  = 4;
  localparam int unsigned FPI = 2;
  localparam int unsigned AW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_sof, s_ready;
  logic [15:0]   s_data;
  logic          enc_en;
  logic [15:0]   enc_data;
  logic [AW-1:0] enc_chan;
  logic          inf_start, inference_done;
  logic          host_req, host_gnt, host_wr;
  logic [AW-1:0] host_adr;
  logic [15:0]   host_dat;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_adr;
  logic [15:0]   mem_dat;
  logic          busy, sof_err;

  typedef struct packed {
    logic [15:0]   data;
    logic [AW-1:0] chan;
    logic          inf;
    logic [31:0]   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  encoding_scheduler #(.CHANNELS(CH), .FRAMES_PER_INF(FPI)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data), .s_ready(s_ready),
    .enc_en(enc_en), .enc_data(enc_data), .enc_chan(enc_chan),
    .inf_start(inf_start), .inference_done(inference_done),
    .host_req(host_req), .host_gnt(host_gnt), .host_wr(host_wr),
    .host_adr(host_adr), .host_dat(host_dat),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_adr(mem_adr), .mem_dat(mem_dat),
    .busy(busy), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding handshake, one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (enc_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected enc_en", 32'(enc_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("enc_data", 32'(enc_data), 32'(e.data));
        check("enc_chan", 32'(enc_chan), 32'(e.chan));
        check("enc_inf_start", 32'(inf_start), 32'(e.inf));
        check("enc_latency", 32'(cyc), e.cyc + 32'd1);
      end
    end else if (inf_start !== 1'b0) begin
      check("inf_start without enc_en", 32'(inf_start), 32'd0);
    end
  end

  // One sample offered just after an edge; expectation queued if it handshakes and should emit.
  task automatic send(input logic [15:0] d, input logic sof, input logic emit,
                      input logic [AW-1:0] ch, input logic inf);
    #1;
    s_valid = 1'b1;
    s_sof   = sof;
    s_data  = d;
    @(negedge clk);
    check("s_ready at send", 32'(s_ready), 32'd1);
    if (emit) exp_q.push_back('{data: d, chan: ch, inf: inf, cyc: 32'(cyc)});
    @(posedge clk);
  endtask

  task automatic stop_stream();
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  // Return from WAIT_INF with a done pulse one cycle after the request.
  task automatic finish_inf();
    stop_stream();
    @(posedge clk); #1 inference_done = 1'b1;
    @(posedge clk); #1 inference_done = 1'b0;
    @(negedge clk);
    check("idle after done", 32'(busy), 32'd0);
    @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " s_ready"},   32'(s_ready),   32'd0);
    check({tag, " enc_en"},    32'(enc_en),    32'd0);
    check({tag, " enc_data"},  32'(enc_data),  32'd0);
    check({tag, " enc_chan"},  32'(enc_chan),  32'd0);
    check({tag, " inf_start"}, 32'(inf_start), 32'd0);
    check({tag, " host_gnt"},  32'(host_gnt),  32'd0);
    check({tag, " mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, " mem_wr_en"}, 32'(mem_wr_en), 32'd0);
    check({tag, " mem_adr"},   32'(mem_adr),   32'd0);
    check({tag, " mem_dat"},   32'(mem_dat),   32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " sof_err"},   32'(sof_err),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; inference_done = 1'b0;
    host_req = 1'b1; host_wr = 1'b1; host_adr = 2'd3; host_dat = 16'hFFFF;
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    host_req = 1'b0; host_wr = 1'b0; host_adr = '0; host_dat = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal frame, no inference request yet.
    send(16'h0001, 1'b1, 1'b1, 2'd0, 1'b0);
    send(16'h0002, 1'b0, 1'b1, 2'd1, 1'b0);
    send(16'h0003, 1'b0, 1'b1, 2'd2, 1'b0);
    send(16'h0004, 1'b0, 1'b1, 2'd3, 1'b0);
    stop_stream();
    @(negedge clk);
    check("nominal busy", 32'(busy), 32'd0);
    check("nominal s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);

    // Second frame triggers inference; coincident done ignored, later done releases.
    send(16'h0011, 1'b1, 1'b1, 2'd0, 1'b0);
    send(16'h0012, 1'b0, 1'b1, 2'd1, 1'b0);
    send(16'h0013, 1'b0, 1'b1, 2'd2, 1'b0);
    send(16'h0014, 1'b0, 1'b1, 2'd3, 1'b1);
    #1 s_valid = 1'b0; inference_done = 1'b1;
    @(negedge clk);
    check("wait inf_start", 32'(inf_start), 32'd1);
    check("wait s_ready", 32'(s_ready), 32'd0);
    check("wait busy", 32'(busy), 32'd1);
    @(posedge clk); #1 inference_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("gated s_ready", 32'(s_ready), 32'd0);
    end
    @(posedge clk); #1 inference_done = 1'b1;
    @(posedge clk); #1 inference_done = 1'b0;
    @(negedge clk);
    check("released s_ready", 32'(s_ready), 32'd1);
    check("released busy", 32'(busy), 32'd0);
    @(posedge clk);

    // Misalignment: stray sample dropped, then early sof restarts the frame uncounted.
    send(16'h0055, 1'b0, 1'b0, 2'd0, 1'b0);
    stop_stream();
    @(negedge clk);
    check("drop sof_err", 32'(sof_err), 32'd1);
    check("drop busy", 32'(busy), 32'd0);
    @(posedge clk);
    send(16'h0021, 1'b1, 1'b1, 2'd0, 1'b0);
    send(16'h0022, 1'b0, 1'b1, 2'd1, 1'b0);
    send(16'h0023, 1'b1, 1'b1, 2'd0, 1'b0);
    send(16'h0024, 1'b0, 1'b1, 2'd1, 1'b0);
    send(16'h0025, 1'b0, 1'b1, 2'd2, 1'b0);
    send(16'h0026, 1'b0, 1'b1, 2'd3, 1'b0);
    send(16'h0031, 1'b1, 1'b1, 2'd0, 1'b0);
    send(16'h0032, 1'b0, 1'b1, 2'd1, 1'b0);
    send(16'h0033, 1'b0, 1'b1, 2'd2, 1'b0);
    send(16'h0034, 1'b0, 1'b1, 2'd3, 1'b1);
    finish_inf();
    check("sticky sof_err", 32'(sof_err), 32'd1);

    // Host request mid-frame waits for the frame to finish.
    send(16'h0041, 1'b1, 1'b1, 2'd0, 1'b0);
    send(16'h0042, 1'b0, 1'b1, 2'd1, 1'b0);
    #1 host_req = 1'b1;
    send(16'h0043, 1'b0, 1'b1, 2'd2, 1'b0);
    check("host wait gnt", 32'(host_gnt), 32'd0);
    send(16'h0044, 1'b0, 1'b1, 2'd3, 1'b0);
    stop_stream();
    @(negedge clk);
    check("host pre gnt", 32'(host_gnt), 32'd0);
    check("host pre s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1 host_wr = 1'b1; host_adr = 2'd2; host_dat = 16'hBEEF;
    @(negedge clk);
    check("host gnt", 32'(host_gnt), 32'd1);
    check("host busy", 32'(busy), 32'd1);
    check("wr mem_wr_en", 32'(mem_wr_en), 32'd1);
    check("wr mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("wr mem_adr", 32'(mem_adr), 32'd2);
    check("wr mem_dat", 32'(mem_dat), 32'hBEEF);
    @(posedge clk);
    #1 host_wr = 1'b0; host_adr = 2'd1;
    @(negedge clk);
    check("rd mem_rd_en", 32'(mem_rd_en), 32'd1);
    check("rd mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("rd mem_adr", 32'(mem_adr), 32'd1);
    @(posedge clk);
    #1 host_req = 1'b0;
    @(negedge clk);
    check("drop req mem_rd_en", 32'(mem_rd_en), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("release gnt", 32'(host_gnt), 32'd0);
    check("release busy", 32'(busy), 32'd0);
    check("release s_ready", 32'(s_ready), 32'd1);
    check("release mem_adr", 32'(mem_adr), 32'd0);
    check("release mem_dat", 32'(mem_dat), 32'd0);
    @(posedge clk);

    // Simultaneous host request and start-of-frame: host wins, sample stays pending.
    #1 host_req = 1'b1; s_valid = 1'b1; s_sof = 1'b1; s_data = 16'h0077;
    @(negedge clk);
    check("simul s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("simul host_gnt", 32'(host_gnt), 32'd1);
    check("simul enc_en", 32'(enc_en), 32'd0);
    check("simul s_ready held", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1 host_req = 1'b0;
    @(posedge clk);
    send(16'h0077, 1'b1, 1'b1, 2'd0, 1'b0);
    send(16'h0078, 1'b0, 1'b1, 2'd1, 1'b0);
    send(16'h0079, 1'b0, 1'b1, 2'd2, 1'b0);
    send(16'h007A, 1'b0, 1'b1, 2'd3, 1'b1);
    finish_inf();

    // Reset mid-frame clears everything; a fresh frame then starts at channel 0.
    send(16'h0091, 1'b1, 1'b1, 2'd0, 1'b0);
    send(16'h0092, 1'b0, 1'b1, 2'd1, 1'b0);
    #1 s_valid = 1'b1; s_sof = 1'b0; s_data = 16'h0093;
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_all_zero("mid reset");
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    send(16'h00A1, 1'b1, 1'b1, 2'd0, 1'b0);
    send(16'h00A2, 1'b0, 1'b1, 2'd1, 1'b0);
    send(16'h00A3, 1'b0, 1'b1, 2'd2, 1'b0);
    send(16'h00A4, 1'b0, 1'b1, 2'd3, 1'b0);
    stop_stream();
    repeat (3) @(negedge clk);
    check("post reset busy", 32'(busy), 32'd0);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encoding_scheduler.md
Name: encoding_scheduler

Overview:
Frame-level controller placed in front of the encoding slot. It takes the channel-interleaved sample stream from acquisition, checks frame alignment, and feeds the slot one channel per cycle. After a set number of frames it requests one inference and holds off new frames until that inference completes. It also shares the slot's sample-memory port with a host, granting the host only between frames.

Parameters:
CHANNELS, 128, samples per frame (channel 0..CHANNELS-1)
FRAMES_PER_INF, 16, complete frames streamed per inference request
AW, clogb2(CHANNELS-1), channel/address width (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
s_valid  in  1  acquisition sample valid
s_sof  in  1  start-of-frame; qualifies channel 0 sample
s_data  in  16  signed sample
s_ready  out  1  scheduler accepts sample
enc_en  out  1  one-cycle strobe to encoding slot en
enc_data  out  16  sample to encoding slot data_in
enc_chan  out  AW  channel index of enc_data
inf_start  out  1  one-cycle inference request
inference_done  in  1  inference completion pulse
host_req  in  1  host requests sample-memory port
host_gnt  out  1  host owns sample-memory port
host_wr  in  1  host write (else read)
host_adr  in  AW  host address
host_dat  in  16  host write data
mem_rd_en  out  1  to slot sample-memory rd_en
mem_wr_en  out  1  to slot sample-memory wr_en
mem_adr  out  AW  to slot sample-memory address
mem_dat  out  16  to slot sample-memory write data
busy  out  1  state != IDLE
sof_err  out  1  sticky frame-alignment error; cleared only by reset

Behaviour:
- Reset (rst=0, async): state IDLE, channel counter 0, frame counter 0. Every output is 0, including s_ready, enc_*, inf_start, host_gnt, mem_* and sof_err. A partially streamed frame is discarded.
- States:
  - IDLE -> HOST if host_req=1. Host has priority over the stream in IDLE.
  - IDLE -> STREAM otherwise, on s_valid & s_sof.
  - STREAM -> IDLE after the channel CHANNELS-1 handshake, or -> WAIT_INF if that frame makes frame_cnt reach FRAMES_PER_INF.
  - WAIT_INF -> IDLE on inference_done.
  - HOST -> IDLE when host_req=0.
- s_ready:
  - 1 in IDLE when host_req=0.
  - 1 in STREAM.
  - 0 in WAIT_INF and HOST.
- Handshake is s_valid & s_ready. Registered output, 1-cycle latency: the cycle after a handshake, enc_en=1, enc_data=s_data, enc_chan=channel counter. enc_en=0 when there is no handshake. Zero bubbles: back-to-back handshakes give back-to-back strobes.
- Alignment:
  - In IDLE, a handshake with s_sof=0: sample dropped (no enc_en), sof_err set, state stays IDLE.
  - In STREAM, s_sof=1 at a channel other than 0: sof_err set, counter restarts, and that sample is emitted as channel 0. The aborted frame is not counted.
- Channel counter increments on each STREAM handshake and wraps to 0 after CHANNELS-1.
- Frame counter:
  - Increments when a frame completes.
  - On reaching FRAMES_PER_INF: clears to 0, inf_start pulses for 1 cycle (the cycle after the last handshake, coincident with the last enc_en), state enters WAIT_INF.
- inference_done is sampled only in WAIT_INF and ignored in other states. A pulse arriving in the same cycle as inf_start is ignored. WAIT_INF has no timeout.
- host_req arriving during STREAM or WAIT_INF waits; it is granted on the first cycle in IDLE. host_gnt is registered and is 1 only in HOST.
- Memory port, combinational and gated by host_gnt:
  - mem_rd_en = host_gnt & ~host_wr & host_req
  - mem_wr_en = host_gnt & host_wr & host_req
  - mem_adr = host_gnt ? host_adr : 0
  - mem_dat = host_gnt ? host_dat : 0
  - Read data returns directly from the slot, not through this block.
- If host_req and s_valid&s_sof are both high in IDLE: HOST wins. The stream sample is not accepted (s_ready=0) and stays pending.
- Widths: AW-bit counters; frame counter is clogb2(FRAMES_PER_INF)+1 bits. No arithmetic on samples; data passes through unchanged.

Test Plan:
- Nominal frame: CHANNELS=4, FRAMES_PER_INF=2. Stream 4 samples with sof on the first, values 0x0001..0x0004. -> enc_en high for 4 consecutive cycles, each 1 cycle after its handshake; enc_chan 0,1,2,3; state returns to IDLE; inf_start stays 0.
- Inference gating: stream 2 full frames. -> inf_start pulses once, coincident with the 8th enc_en; s_ready=0 until inference_done. A pulse of inference_done in that same cycle is ignored; a pulse 5 cycles later returns to IDLE and s_ready=1.
- Misalignment: sample with s_sof=0 in IDLE -> dropped, sof_err=1. Then sof asserted at channel 2 mid-frame -> that sample is emitted with enc_chan=0, and the frame counter does not advance for the aborted frame.
- Host arbitration: host_req rises mid-frame. -> host_gnt waits until after the channel-3 handshake, then rises. A write to adr 2 with 0xBEEF gives mem_wr_en=1, mem_adr=2, mem_dat=0xBEEF. Dropping host_req -> IDLE next cycle.
- Simultaneous request: host_req and s_valid&s_sof in the same IDLE cycle -> host_gnt=1, s_ready=0, no enc_en.
- Reset mid-operation: assert rst low at channel 2 of a frame -> all outputs 0 immediately, sof_err cleared. After release, a fresh frame starts at enc_chan=0.
